// File: rtl/rpn_stack_sequencer.sv
// rtl/rpn_stack_sequencer.sv - RPN token FIFO and micro-op sequencer driving the stack unit.
// Optional saturation of overflowed add/mul results: define RPN_SEQ_SAT_EN.
module rpn_stack_sequencer #(
  parameter int N          = 8,
  parameter int MAX_SIZE   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tok_valid,
  output logic                             tok_ready,
  input  logic [1:0]                       tok_kind,
  input  logic [N-1:0]                     tok_value,
  output logic [2:0]                       alu_opcode,
  output logic [N-1:0]                     alu_data,
  input  logic [N-1:0]                     alu_result,
  input  logic                             alu_overflow,
  input  logic                             alu_success,
  output logic                             res_valid,
  output logic [N-1:0]                     res_data,
  output logic                             res_overflow,
  output logic                             res_error,
  output logic [$clog2(MAX_SIZE+1)-1:0]    depth
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam int CW = $clog2(ISSUE_GAP + 1);

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_EVAL, S_DRAIN, S_REPORT
  } state_t;

  logic [N+1:0]   r_fifo [FIFO_DEPTH];
  logic [AW:0]    r_wptr, r_rptr;
  logic           w_full, w_empty, w_wr, w_rd;
  logic [N+1:0]   w_head;
  logic [1:0]     w_head_kind;
  logic [N-1:0]   w_head_value;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_kind;
  logic [1:0]     r_step;
  logic           r_drain;
  logic           r_err;
  logic           r_ovf_acc;
  logic [N-1:0]   r_acc;
  logic           r_cap_ok;
  logic [N-1:0]   r_cap_res;
  logic           r_cap_ovf;
  logic [DW-1:0]  r_depth;
  logic [2:0]     r_alu_opcode;
  logic [N-1:0]   r_alu_data;
  logic           r_res_valid;
  logic [N-1:0]   r_res_data;
  logic           r_res_overflow;
  logic           r_res_error;
  logic [N-1:0]   w_push_val;

  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty      = (r_wptr == r_rptr);
  assign w_wr         = tok_valid && !w_full;
  assign w_rd         = ((r_state == S_IDLE) || (r_state == S_FETCH)) && !w_empty;
  assign w_head       = r_fifo[r_rptr[AW-1:0]];
  assign w_head_kind  = w_head[N+1:N];
  assign w_head_value = w_head[N-1:0];

`ifdef RPN_SEQ_SAT_EN
  logic [N-1:0] r_opa;
  logic         r_acc_ovf;
  logic         w_sat_neg;
  // r_opa is the top (first POP); r_cap_res is the next entry (second POP) in step 2.
  assign w_sat_neg  = (r_kind == K_ADD) ? (r_opa[N-1] & r_cap_res[N-1])
                                        : (r_opa[N-1] ^ r_cap_res[N-1]);
  assign w_push_val = !r_acc_ovf ? r_acc :
                      w_sat_neg  ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
  assign w_push_val = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wptr[AW-1:0]] <= {tok_kind, tok_value};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_kind         <= K_OPND;
      r_step         <= 2'd0;
      r_drain        <= 1'b0;
      r_err          <= 1'b0;
      r_ovf_acc      <= 1'b0;
      r_acc          <= '0;
      r_cap_ok       <= 1'b0;
      r_cap_res      <= '0;
      r_cap_ovf      <= 1'b0;
      r_depth        <= '0;
      r_alu_opcode   <= OP_IDLE;
      r_alu_data     <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_overflow <= 1'b0;
      r_res_error    <= 1'b0;
`ifdef RPN_SEQ_SAT_EN
      r_opa          <= '0;
      r_acc_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FETCH: begin
          r_state <= S_FETCH;
          if (!w_empty) begin
            r_kind <= w_head_kind;
            r_step <= 2'd0;
            // After an error, tokens are swallowed until the end token arrives.
            if (r_err) begin
              if (w_head_kind == K_END) r_state <= S_DRAIN;
            end else begin
              case (w_head_kind)
                K_OPND: begin
                  r_alu_opcode <= OP_PUSH;
                  r_alu_data   <= w_head_value;
                  r_state      <= S_ISSUE;
                end
                K_ADD, K_MUL: begin
                  if (r_depth < DW'(2)) begin
                    r_err <= 1'b1;
                  end else begin
                    r_alu_opcode <= (w_head_kind == K_ADD) ? OP_ADD : OP_MUL;
                    r_state      <= S_ISSUE;
                  end
                end
                default: begin
                  if (r_depth == DW'(1)) begin
                    r_alu_opcode <= OP_POP;
                    r_state      <= S_ISSUE;
                  end else begin
                    r_state <= S_DRAIN;
                  end
                end
              endcase
            end
          end
        end

        S_ISSUE: begin
          r_alu_opcode <= OP_IDLE;
          r_cnt        <= CW'(1);
          r_state      <= S_WAIT;
        end

        S_WAIT: begin
          if (r_cnt == CW'(ISSUE_GAP)) begin
            r_cap_ok  <= alu_success;
            r_cap_res <= alu_result;
            r_cap_ovf <= alu_overflow;
            r_state   <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_EVAL: begin
          if (r_drain) begin
            if (r_cap_ok) begin
              if (r_depth != '0) r_depth <= r_depth - DW'(1);
              r_state <= S_DRAIN;
            end else begin
              r_res_valid    <= 1'b1;
              r_res_data     <= '0;
              r_res_overflow <= r_ovf_acc;
              r_res_error    <= 1'b1;
              r_state        <= S_REPORT;
            end
          end else if (r_kind == K_OPND) begin
            if (r_cap_ok && (r_depth != DW'(MAX_SIZE))) r_depth <= r_depth + DW'(1);
            if (!r_cap_ok) r_err <= 1'b1;
            r_state <= S_FETCH;
          end else if (r_kind == K_END) begin
            if (r_cap_ok) begin
              r_depth        <= '0;
              r_res_valid    <= 1'b1;
              r_res_data     <= r_cap_res;
              r_res_overflow <= r_ovf_acc;
              r_res_error    <= 1'b0;
              r_state        <= S_REPORT;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DRAIN;
            end
          end else if (!r_cap_ok) begin
            r_err   <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            // Arithmetic: op (peek) -> POP -> POP -> PUSH(result).
            case (r_step)
              2'd0: begin
                r_acc        <= r_cap_res;
                r_ovf_acc    <= r_ovf_acc | r_cap_ovf;
`ifdef RPN_SEQ_SAT_EN
                r_acc_ovf    <= r_cap_ovf;
`endif
                r_alu_opcode <= OP_POP;
                r_step       <= 2'd1;
                r_state      <= S_ISSUE;
              end
              2'd1: begin
                if (r_depth != '0) r_depth <= r_depth - DW'(1);
`ifdef RPN_SEQ_SAT_EN
                r_opa        <= r_cap_res;
`endif
                r_alu_opcode <= OP_POP;
                r_step       <= 2'd2;
                r_state      <= S_ISSUE;
              end
              2'd2: begin
                if (r_depth != '0) r_depth <= r_depth - DW'(1);
                r_alu_opcode <= OP_PUSH;
                r_alu_data   <= w_push_val;
                r_step       <= 2'd3;
                r_state      <= S_ISSUE;
              end
              default: begin
                if (r_depth != DW'(MAX_SIZE)) r_depth <= r_depth + DW'(1);
                r_state <= S_FETCH;
              end
            endcase
          end
        end

        S_DRAIN: begin
          if (r_depth == '0) begin
            r_res_valid    <= 1'b1;
            r_res_data     <= '0;
            r_res_overflow <= r_ovf_acc;
            r_res_error    <= 1'b1;
            r_state        <= S_REPORT;
          end else begin
            r_drain      <= 1'b1;
            r_alu_opcode <= OP_POP;
            r_state      <= S_ISSUE;
          end
        end

        S_REPORT: begin
          r_res_valid    <= 1'b0;
          r_res_data     <= '0;
          r_res_overflow <= 1'b0;
          r_res_error    <= 1'b0;
          r_err          <= 1'b0;
          r_ovf_acc      <= 1'b0;
          r_drain        <= 1'b0;
          r_state        <= S_FETCH;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tok_ready    = !w_full;
  assign alu_opcode   = r_alu_opcode;
  assign alu_data     = r_alu_data;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_overflow = r_res_overflow;
  assign res_error    = r_res_error;
  assign depth        = r_depth;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// tb/tb_rpn_stack_sequencer.sv - scoreboard bench for rpn_stack_sequencer with a behavioural stack unit.
module tb_rpn_stack_sequencer;
  localparam int N    = 8;
  localparam int MAX  = 8;
  localparam int FD   = 4;
  localparam int GAP  = 2;
  localparam int DW   = $clog2(MAX + 1);
  localparam int SMAX = (1 <<< (N - 1)) - 1;
  localparam int SMIN = -(1 <<< (N - 1));

  typedef struct {
    logic [N-1:0] data;
    logic         ovf;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tok_valid;
  logic          tok_ready;
  logic [1:0]    tok_kind;
  logic [N-1:0]  tok_value;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result;
  logic          alu_overflow;
  logic          alu_success;
  logic          res_valid;
  logic [N-1:0]  res_data;
  logic          res_overflow;
  logic          res_error;
  logic [DW-1:0] depth;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [1:0] q_k[$];
  int         q_v[$];
  bit  saw_stall;
  int  max_depth;

  always #5 clk = ~clk;

  rpn_stack_sequencer #(.N(N), .MAX_SIZE(MAX), .FIFO_DEPTH(FD), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_value(tok_value),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .alu_success(alu_success),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
    .res_error(res_error), .depth(depth)
  );

  // Behavioural stack unit: registered outputs, updated only when an opcode is presented.
  logic [N-1:0] stk [MAX];
  int sp;
  int m_a, m_b, m_r;
  always @(posedge clk) begin
    if (!rst) begin
      sp = 0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
      alu_success  <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: begin
          alu_overflow <= 1'b0;
          if (sp < MAX) begin
            stk[sp] = alu_data; sp++;
            alu_result <= alu_data; alu_success <= 1'b1;
          end else alu_success <= 1'b0;
        end
        3'b111: begin
          alu_overflow <= 1'b0;
          if (sp > 0) begin
            sp--; alu_result <= stk[sp]; alu_success <= 1'b1;
          end else alu_success <= 1'b0;
        end
        3'b100, 3'b101: begin
          if (sp >= 2) begin
            m_a = int'($signed(stk[sp-1]));
            m_b = int'($signed(stk[sp-2]));
            m_r = (alu_opcode == 3'b100) ? m_a + m_b : m_a * m_b;
            alu_result   <= m_r[N-1:0];
            alu_overflow <= (m_r > SMAX) || (m_r < SMIN);
            alu_success  <= 1'b1;
          end else begin
            alu_success  <= 1'b0;
            alu_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      if (tok_valid && !tok_ready) saw_stall = 1'b1;
      if (int'(depth) > max_depth) max_depth = int'(depth);
      if (res_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result got data=%0d err=%0b", $signed(res_data), res_error);
        end else begin
          e = sb.pop_front();
          total += 4;
          if (res_data !== e.data) begin
            bad++; $display("FAIL res_data got=%0d want=%0d", $signed(res_data), $signed(e.data));
          end
          if (res_overflow !== e.ovf) begin
            bad++; $display("FAIL res_overflow got=%0b want=%0b", res_overflow, e.ovf);
          end
          if (res_error !== e.err) begin
            bad++; $display("FAIL res_error got=%0b want=%0b", res_error, e.err);
          end
          if (depth !== DW'(0)) begin
            bad++; $display("FAIL depth_at_report got=%0d want=0", depth);
          end
        end
      end
    end
  end

  task automatic send_tok(input logic [1:0] k, input int v);
    int n = 0;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_value = v[N-1:0];
    while (!tok_ready && n < 500) begin @(negedge clk); n++; end
    if (!tok_ready) begin
      total++; bad++; $display("FAIL send_timeout got=ready0 want=ready1");
    end
    @(negedge clk);
  endtask

  task automatic wait_results();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL result_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_expr(input logic [N-1:0] d, input logic o, input logic e);
    sb.push_back('{data: d, ovf: o, err: e});
    foreach (q_k[i]) send_tok(q_k[i], q_v[i]);
    tok_valid = 1'b0;
    wait_results();
    q_k.delete(); q_v.delete();
  endtask

  task automatic tok(input logic [1:0] k, input int v);
    q_k.push_back(k); q_v.push_back(v);
  endtask

  // Software RPN reference over the queued token list.
  task automatic sw_eval(output logic [N-1:0] d, output logic o, output logic e);
    int st[$];
    int a, b, r;
    logic [N-1:0] w;
    o = 1'b0; e = 1'b0; d = '0;
    foreach (q_k[i]) begin
      if (q_k[i] == 2'b11) begin
        if (!e && st.size() == 1) d = st[0][N-1:0];
        else begin e = 1'b1; d = '0; end
      end else if (!e) begin
        if (q_k[i] == 2'b00) begin
          if (st.size() == MAX) e = 1'b1;
          else st.push_back(q_v[i]);
        end else if (st.size() < 2) begin
          e = 1'b1;
        end else begin
          a = st.pop_back(); b = st.pop_back();
          r = (q_k[i] == 2'b01) ? a + b : a * b;
          w = r[N-1:0];
          r = int'($signed(w));
          if ((q_k[i] == 2'b01 ? a + b : a * b) > SMAX || (q_k[i] == 2'b01 ? a + b : a * b) < SMIN) begin
            o = 1'b1;
`ifdef RPN_SEQ_SAT_EN
            if (q_k[i] == 2'b01) r = (a < 0 && b < 0) ? SMIN : SMAX;
            else r = ((a < 0) != (b < 0)) ? SMIN : SMAX;
`endif
          end
          st.push_back(r);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; tok_valid = 1'b0; tok_kind = 2'b00; tok_value = '0;
    repeat (3) @(negedge clk);
    total += 4;
    if (alu_opcode !== 3'b000 || alu_data !== '0) begin
      bad++; $display("FAIL reset_alu got=%b/%0d want=000/0", alu_opcode, alu_data);
    end
    if (res_valid !== 1'b0 || res_data !== '0) begin
      bad++; $display("FAIL reset_res got=%0b/%0d want=0/0", res_valid, res_data);
    end
    if (res_overflow !== 1'b0 || res_error !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%0b%0b want=00", res_overflow, res_error);
    end
    if (depth !== DW'(0)) begin
      bad++; $display("FAIL reset_depth got=%0d want=0", depth);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tok_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%0b want=1", tok_ready);
    end
  endtask

  task automatic test_add();
    tok(2'b00, 3); tok(2'b00, 4); tok(2'b01, 0); tok(2'b11, 0);
    run_expr(8'd7, 1'b0, 1'b0);
  endtask

  task automatic test_mul_overflow();
    tok(2'b00, 100); tok(2'b00, 2); tok(2'b10, 0); tok(2'b11, 0);
`ifdef RPN_SEQ_SAT_EN
    run_expr(8'd127, 1'b1, 1'b0);
`else
    run_expr(8'hC8, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_underflow();
    tok(2'b00, 5); tok(2'b01, 0); tok(2'b11, 0);
    run_expr(8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_stack_full();
    max_depth = 0;
    for (int i = 1; i <= MAX + 1; i++) tok(2'b00, i);
    tok(2'b11, 0);
    run_expr(8'd0, 1'b0, 1'b1);
    total++;
    if (max_depth != MAX) begin
      bad++; $display("FAIL max_depth got=%0d want=%0d", max_depth, MAX);
    end
  endtask

  task automatic test_back_to_back();
    saw_stall = 1'b0;
    tok(2'b00, 1); tok(2'b00, 2); tok(2'b01, 0); tok(2'b00, 3); tok(2'b10, 0); tok(2'b11, 0);
    run_expr(8'd9, 1'b0, 1'b0);
    total++;
    if (saw_stall !== 1'b1) begin
      bad++; $display("FAIL burst_stall got=%0b want=1", saw_stall);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic o, e;
    for (int it = 0; it < 5; it++) begin
      tok(2'b00, int'($urandom_range(0, 60)) - 30);
      for (int j = 0; j < 3; j++) begin
        tok(2'b00, int'($urandom_range(0, 60)) - 30);
        tok($urandom_range(0, 1) ? 2'b01 : 2'b10, 0);
      end
      tok(2'b11, 0);
      sw_eval(d, o, e);
      run_expr(d, o, e);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tok(2'b00, 3); tok(2'b00, 4); tok(2'b10, 0);
    foreach (q_k[i]) send_tok(q_k[i], q_v[i]);
    tok_valid = 1'b0;
    q_k.delete(); q_v.delete();
    while (alu_opcode !== 3'b101 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (alu_opcode !== 3'b101) begin
      bad++; $display("FAIL mul_issue_timeout got=%b want=101", alu_opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (alu_opcode !== 3'b000) begin
      bad++; $display("FAIL midreset_opcode got=%b want=000", alu_opcode);
    end
    if (depth !== DW'(0)) begin
      bad++; $display("FAIL midreset_depth got=%0d want=0", depth);
    end
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_valid got=%0b want=0", res_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    tok(2'b00, 2); tok(2'b00, 3); tok(2'b01, 0); tok(2'b11, 0);
    run_expr(8'd5, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_overflow();
    test_underflow();
    test_stack_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_stack_sequencer.md
Name: rpn_stack_sequencer

Overview:
- Upstream controller for the ALU-based stack unit. Accepts a stream of RPN tokens (operand, add, mul, end) over a valid/ready handshake and buffers them in a small FIFO.
- Expands each token into opcode micro-ops on the stack unit's opcode/data port, checks their success/overflow, and reports one result per expression.
- Stack unit semantics relied on: ADD/MUL peek the top two entries, restore them, and return the result. The sequencer therefore follows each arithmetic op with POP, POP, PUSH(result).

Parameters:
- N, 8, data width (signed), equal to the stack unit's N
- MAX_SIZE, 8, stack capacity, equal to the stack unit's MAX_SIZE
- FIFO_DEPTH, 4, token FIFO entries (power of two)
- ISSUE_GAP, 2, cycles from opcode issue to sampling alu_success/alu_result/alu_overflow (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- tok_valid  in  1  token present
- tok_ready  out  1  FIFO not full
- tok_kind  in  2  00 operand, 01 add, 10 mul, 11 end
- tok_value  in  N  signed operand; ignored unless kind=00
- alu_opcode  out  3  to stack unit: 110 push, 111 pop, 100 add, 101 mul, 000 idle
- alu_data  out  N  push data to stack unit
- alu_result  in  N  stack unit output_data
- alu_overflow  in  1  stack unit overflow
- alu_success  in  1  stack unit success
- res_valid  out  1  one-cycle pulse, expression complete
- res_data  out  N  final value; 0 on error
- res_overflow  out  1  sticky OR of arithmetic overflow within the expression
- res_error  out  1  expression failed
- depth  out  clog2(MAX_SIZE+1)  tracked stack occupancy

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; FSM to IDLE; depth=0
  - alu_opcode=000, alu_data=0
  - res_valid=0, res_data=0, res_overflow=0, res_error=0
  - tok_ready=1 from the cycle after reset release
  - Reset mid-sequence aborts immediately with no result pulse. The stack unit shares rst and is cleared by the integration.
- FIFO:
  - A token is written when tok_valid && tok_ready. tok_ready = !fifo_full.
  - Simultaneous write and read on a full FIFO is not allowed: ready stays low while full.
- Micro-op issue:
  - alu_opcode holds the op for exactly one cycle T, then 000.
  - Results are sampled at cycle T+ISSUE_GAP; the next micro-op issues no earlier than T+ISSUE_GAP+1.
  - alu_data is held stable from T through the sample cycle.
- FSM states: IDLE, FETCH, ISSUE, WAIT, EVAL, DRAIN, REPORT.
  - IDLE/FETCH: pop one FIFO token when FIFO non-empty.
  - Operand: PUSH(tok_value). On success, depth+1; on failure (full), set err.
  - Add/mul:
    - If depth<2, set err with no issue.
    - Otherwise issue 100/101, capture alu_result and OR alu_overflow into res_overflow.
    - Then POP, POP (depth-2), then PUSH(captured), depth+1.
    - Any success=0 within the sequence sets err.
  - End:
    - If !err and depth==1: POP; res_data=alu_result; depth=0; go to REPORT.
    - Otherwise go to DRAIN.
  - err set before end: remaining tokens are consumed and discarded without issue until end, then DRAIN.
  - DRAIN: POP repeatedly until depth==0, then REPORT with res_error=1, res_data=0.
  - REPORT: res_valid=1 for one cycle. res_overflow/res_error are valid with it and cleared the following cycle. Next state FETCH.
- Arithmetic: the captured result is the stack unit's N-bit output, pushed unmodified (wrap) unless the optional feature is enabled.
- depth never exceeds MAX_SIZE and never underflows. It changes only on sampled success.

Optional Feature:
- Macro: RPN_SEQ_SAT_EN
- Defined: when the captured add/mul result has alu_overflow=1, the pushed value saturates.
  - Add: sign taken from the operands. Both negative gives -2^(N-1); both non-negative gives 2^(N-1)-1.
  - Mul: sign from the XOR of the operand signs, saturated the same way.
  - Operands are captured from the two POPs, which return top then next.
  - res_overflow still reports the event.
- Undefined: the wrapped N-bit value is pushed.

Test Plan:
- Tokens 3, 4, add, end → res_valid once, res_data=7, res_overflow=0, res_error=0, depth back to 0.
- N=8: 100, 2, mul, end → overflow flagged. Without the macro, res_data=-56 (200 wrapped). With RPN_SEQ_SAT_EN, res_data=127. res_overflow=1 in both cases.
- Tokens 5, add, end → add skipped (depth<2); DRAIN pops 1 entry; res_error=1, res_data=0, depth=0.
- MAX_SIZE+1 operands then end → last push has success=0 → err; DRAIN pops MAX_SIZE entries; res_error=1.
- Burst of 6 tokens with FIFO_DEPTH=4 and tok_valid held high → tok_ready drops while the FIFO is full. No token is lost or duplicated; the result equals the software RPN evaluation.
- rst=0 asserted during the WAIT of a mul sequence → next cycle alu_opcode=000, depth=0, no res_valid. A new expression 2, 3, add, end then gives res_data=5.
